// File: rtl/lock_bank_arbiter.sv
// Two-requester round-robin front end for a bank of sticky-lockable configuration registers.
// Each accepted access runs IDLE -> EXEC -> RESP; writes to locked targets return err.
module lock_bank_arbiter #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [ADDR_W-1:0]          a_addr,
  input  logic [DATA_W-1:0]          a_data,
  input  logic                       a_lock,
  output logic                       a_ack,
  output logic                       a_err,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [ADDR_W-1:0]          b_addr,
  input  logic [DATA_W-1:0]          b_data,
  input  logic                       b_lock,
  output logic                       b_ack,
  output logic                       b_err,
  input  logic                       lock_all,
  output logic [NUM_REGS-1:0]        locked,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic                       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                rr_b;
  logic                grant_a;
  logic                grant_b;
  logic                accept;
  logic                req_b;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                lock_q;
  logic                in_range;
  logic                hit_locked;
  logic                target_locked;
  logic                wr_en;

  // Next state and combinational grant; rr_b set means B wins a tie.
  always_comb begin
    state_nxt = state;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    case (state)
      IDLE: begin
        if (a_valid && (!b_valid || !rr_b)) begin
          grant_a = 1'b1;
        end else if (b_valid) begin
          grant_b = 1'b1;
        end
        if (grant_a || grant_b) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept  = grant_a | grant_b;
  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign busy    = (state != IDLE);

  // Out-of-range addresses are treated as permanently locked.
  always_comb begin
    in_range   = 1'b0;
    hit_locked = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == ADDR_W'(i)) begin
        in_range   = 1'b1;
        hit_locked = locked[i];
      end
    end
    target_locked = lock_all | ~in_range | hit_locked;
    wr_en         = (state == EXEC) && !target_locked;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_b   <= 1'b0;
      req_b  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      lock_q <= 1'b0;
      a_ack  <= 1'b0;
      a_err  <= 1'b0;
      b_ack  <= 1'b0;
      b_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      a_ack <= 1'b0;
      a_err <= 1'b0;
      b_ack <= 1'b0;
      b_err <= 1'b0;
      if (accept) begin
        req_b  <= grant_b;
        addr_q <= grant_b ? b_addr : a_addr;
        data_q <= grant_b ? b_data : a_data;
        lock_q <= grant_b ? b_lock : a_lock;
        rr_b   <= grant_a;
      end
      // Response flags land on the EXEC->RESP edge and live for the RESP cycle only.
      if (state == EXEC) begin
        a_ack <= !req_b && !target_locked;
        a_err <= !req_b &&  target_locked;
        b_ack <=  req_b && !target_locked;
        b_err <=  req_b &&  target_locked;
      end
    end
  end

  // Register bank and sticky locks; lock_all is honoured at every edge in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= '0;
      reg_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && (addr_q == ADDR_W'(i))) begin
          reg_q[i*DATA_W +: DATA_W] <= data_q;
          if (lock_q) locked[i] <= 1'b1;
        end
        if (lock_all) locked[i] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lock_bank_arbiter.sv
// Self-checking bench for lock_bank_arbiter: directed table, multi-cycle sequences,
// and randomized single-port traffic against an array-based bank model.
module tb_lock_bank_arbiter;

  localparam int unsigned NREGS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_lock, a_ready, a_ack, a_err;
  logic [1:0]  a_addr;
  logic [7:0]  a_data;
  logic        b_valid, b_lock, b_ready, b_ack, b_err;
  logic [1:0]  b_addr;
  logic [7:0]  b_data;
  logic        lock_all;
  logic [3:0]  locked;
  logic [31:0] reg_q;
  logic        busy;

  // Second instance with a bank smaller than the address space.
  logic        c_valid, c_lock, c_ready, c_ack, c_err;
  logic [1:0]  c_addr;
  logic [7:0]  c_data;
  logic        c_b_ready, c_b_ack, c_b_err, c_busy;
  logic [2:0]  c_locked;
  logic [23:0] c_regq;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] m_regs [NREGS];
  bit         m_locked [NREGS];

  always #5 clk = ~clk;

  lock_bank_arbiter #(.NUM_REGS(4), .DATA_W(8), .ADDR_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data), .a_lock(a_lock),
    .a_ack(a_ack), .a_err(a_err),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data), .b_lock(b_lock),
    .b_ack(b_ack), .b_err(b_err),
    .lock_all(lock_all), .locked(locked), .reg_q(reg_q), .busy(busy)
  );

  lock_bank_arbiter #(.NUM_REGS(3), .DATA_W(8), .ADDR_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(c_valid), .a_ready(c_ready), .a_addr(c_addr), .a_data(c_data), .a_lock(c_lock),
    .a_ack(c_ack), .a_err(c_err),
    .b_valid(1'b0), .b_ready(c_b_ready), .b_addr(2'd0), .b_data(8'h00), .b_lock(1'b0),
    .b_ack(c_b_ack), .b_err(c_b_err),
    .lock_all(1'b0), .locked(c_locked), .reg_q(c_regq), .busy(c_busy)
  );

  typedef struct {
    bit         is_b;
    logic [1:0] addr;
    logic [7:0] data;
    bit         lk;
    bit         la;
    bit         ack;
    bit         err;
    logic [7:0] reg_v;
    logic [3:0] lkd;
  } vec_t;

  typedef struct {
    bit          timeout;
    bit          exec_busy;
    bit          exec_resp;
    logic [31:0] exec_regq;
    bit          ack;
    bit          err;
    bit          other;
    bit          post;
  } obs_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_pack();
    logic [31:0] v;
    for (int i = 0; i < NREGS; i++) v[i*8 +: 8] = m_regs[i];
    return v;
  endfunction

  function automatic logic [3:0] m_lock_vec();
    logic [3:0] v;
    for (int i = 0; i < NREGS; i++) v[i] = m_locked[i];
    return v;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i]   = 8'h00;
      m_locked[i] = 1'b0;
    end
  endfunction

  // A write succeeds only when nothing protects the target; lock_all then locks the whole bank.
  function automatic void m_apply(input logic [1:0] ad, input logic [7:0] dt, input bit lk,
                                  input bit la, output bit ea, output bit ee);
    bit blocked;
    blocked = la || (int'(ad) >= NREGS) || m_locked[ad];
    if (!blocked) begin
      m_regs[ad] = dt;
      if (lk) m_locked[ad] = 1'b1;
    end
    if (la) for (int i = 0; i < NREGS; i++) m_locked[i] = 1'b1;
    ea = !blocked;
    ee = blocked;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; lock_all = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_clear();
  endtask

  task automatic txn(input bit is_b, input logic [1:0] ad, input logic [7:0] dt,
                     input bit lk, input bit la, output obs_t o);
    int n;
    @(posedge clk); #1;
    if (is_b) begin
      b_valid = 1'b1; b_addr = ad; b_data = dt; b_lock = lk;
    end else begin
      a_valid = 1'b1; a_addr = ad; a_data = dt; a_lock = lk;
    end
    n = 0;
    @(negedge clk);
    while (!(is_b ? b_ready : a_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    o.timeout = (n >= 20);
    @(posedge clk); #1;
    a_valid  = 1'b0;
    b_valid  = 1'b0;
    lock_all = la;
    @(negedge clk);
    o.exec_busy = busy;
    o.exec_resp = a_ack | a_err | b_ack | b_err | a_ready | b_ready;
    o.exec_regq = reg_q;
    @(posedge clk); #1;
    lock_all = 1'b0;
    @(negedge clk);
    o.ack   = is_b ? b_ack : a_ack;
    o.err   = is_b ? b_err : a_err;
    o.other = is_b ? (a_ack | a_err) : (b_ack | b_err);
    @(negedge clk);
    o.post = a_ack | a_err | b_ack | b_err | busy;
  endtask

  task automatic check_txn(input string nm, input bit is_b, input logic [1:0] ad,
                           input logic [7:0] dt, input bit lk, input bit la,
                           output bit got_ack, output bit got_err);
    obs_t        o;
    logic [31:0] pre;
    bit          ea, ee;
    pre = m_pack();
    txn(is_b, ad, dt, lk, la, o);
    m_apply(ad, dt, lk, la, ea, ee);
    check({nm, "_timeout"}, 32'(o.timeout), 32'd0);
    check({nm, "_exec_busy"}, 32'(o.exec_busy), 32'd1);
    check({nm, "_exec_quiet"}, 32'(o.exec_resp), 32'd0);
    check({nm, "_exec_regq"}, o.exec_regq, pre);
    check({nm, "_ack"}, 32'(o.ack), 32'(ea));
    check({nm, "_err"}, 32'(o.err), 32'(ee));
    check({nm, "_other_port"}, 32'(o.other), 32'd0);
    check({nm, "_pulse_end"}, 32'(o.post), 32'd0);
    check({nm, "_regq"}, reg_q, m_pack());
    check({nm, "_locked"}, 32'(locked), 32'(m_lock_vec()));
    got_ack = o.ack;
    got_err = o.err;
  endtask

  task automatic contend(input logic [1:0] aa, input logic [7:0] ad, input logic [1:0] ba,
                         input logic [7:0] bd, output int first, output int second,
                         output bit both_seen);
    int g;
    @(posedge clk); #1;
    a_valid = 1'b1; a_addr = aa; a_data = ad; a_lock = 1'b0;
    b_valid = 1'b1; b_addr = ba; b_data = bd; b_lock = 1'b0;
    first = -1; second = -1; both_seen = 1'b0;
    for (int c = 0; c < 20 && second < 0; c++) begin
      @(negedge clk);
      if (a_ready && b_ready) both_seen = 1'b1;
      g = a_ready ? 0 : (b_ready ? 1 : -1);
      @(posedge clk); #1;
      if (g == 0) a_valid = 1'b0;
      if (g == 1) b_valid = 1'b0;
      if (g >= 0) begin
        if (first < 0) first = g;
        else second = g;
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  vec_t vt [9];

  initial begin
    bit ga, ge, ea, ee, flag;
    int f, s;
    bit both;

    vt[0] = '{1'b0, 2'd1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 4'b0000};
    vt[1] = '{1'b0, 2'd2, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33, 4'b0100};
    vt[2] = '{1'b1, 2'd2, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 4'b0100};
    vt[3] = '{1'b1, 2'd0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 4'b0100};
    vt[4] = '{1'b0, 2'd3, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, 4'b1100};
    vt[5] = '{1'b0, 2'd3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 4'b1100};
    vt[6] = '{1'b1, 2'd1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 8'h77, 4'b1110};
    vt[7] = '{1'b1, 2'd0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 4'b1111};
    vt[8] = '{1'b0, 2'd0, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 4'b1111};

    rst_n = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0; a_lock = 1'b0;
    b_valid = 1'b0; b_addr = '0; b_data = '0; b_lock = 1'b0;
    c_valid = 1'b0; c_addr = '0; c_data = '0; c_lock = 1'b0;
    lock_all = 1'b0;
    m_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("reset_regq", reg_q, 32'h0);
    check("reset_locked", 32'(locked), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_resp", 32'({a_ready, b_ready, a_ack, a_err, b_ack, b_err}), 32'h0);

    for (int i = 0; i < 9; i++) begin
      check_txn($sformatf("vec%0d", i), vt[i].is_b, vt[i].addr, vt[i].data, vt[i].lk, vt[i].la,
                ga, ge);
      check($sformatf("vec%0d_tbl_ack", i), 32'(ga), 32'(vt[i].ack));
      check($sformatf("vec%0d_tbl_err", i), 32'(ge), 32'(vt[i].err));
      check($sformatf("vec%0d_tbl_reg", i), 32'(reg_q[vt[i].addr*8 +: 8]), 32'(vt[i].reg_v));
      check($sformatf("vec%0d_tbl_locked", i), 32'(locked), 32'(vt[i].lkd));
    end

    // Reset during EXEC drops the transaction and clears the bank at once.
    @(posedge clk); #1;
    a_valid = 1'b1; a_addr = 2'd1; a_data = 8'h44; a_lock = 1'b0;
    @(negedge clk);
    check("rst_exec_ready", 32'(a_ready), 32'd1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_exec_regq", reg_q, 32'h0);
    check("rst_exec_locked", 32'(locked), 32'h0);
    check("rst_exec_busy", 32'(busy), 32'h0);
    flag = 1'b0;
    repeat (3) begin
      @(negedge clk);
      flag |= a_ack | a_err | b_ack | b_err;
    end
    @(posedge clk); #1 rst_n = 1'b1;
    m_clear();
    @(negedge clk);
    flag |= a_ack | a_err | b_ack | b_err;
    check("rst_exec_no_resp", 32'(flag), 32'd0);
    check_txn("post_rst", 1'b0, 2'd2, 8'h05, 1'b0, 1'b0, ga, ge);
    check("post_rst_ack", 32'(ga), 32'd1);

    // Contention from a fresh reset: A, then B, then A again on the next tie.
    do_reset();
    contend(2'd0, 8'h10, 2'd1, 8'h20, f, s, both);
    m_apply(2'd0, 8'h10, 1'b0, 1'b0, ea, ee);
    m_apply(2'd1, 8'h20, 1'b0, 1'b0, ea, ee);
    check("rr1_first", 32'(f), 32'd0);
    check("rr1_second", 32'(s), 32'd1);
    check("rr1_both_ready", 32'(both), 32'd0);
    check("rr1_regq", reg_q, m_pack());
    contend(2'd0, 8'h30, 2'd3, 8'h40, f, s, both);
    m_apply(2'd0, 8'h30, 1'b0, 1'b0, ea, ee);
    m_apply(2'd3, 8'h40, 1'b0, 1'b0, ea, ee);
    check("rr2_first", 32'(f), 32'd0);
    check("rr2_second", 32'(s), 32'd1);
    check("rr2_both_ready", 32'(both), 32'd0);
    check("rr2_regq", reg_q, m_pack());

    // Three-register bank: address 3 is out of range and must be rejected.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      c_valid = 1'b1; c_addr = (k == 0) ? 2'd3 : 2'd2; c_data = 8'hAA; c_lock = 1'b0;
      @(negedge clk);
      check($sformatf("d3_%0d_ready", k), 32'(c_ready), 32'd1);
      @(posedge clk); #1;
      c_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("d3_%0d_ack", k), 32'(c_ack), (k == 1) ? 32'd1 : 32'd0);
      check($sformatf("d3_%0d_err", k), 32'(c_err), (k == 0) ? 32'd1 : 32'd0);
      check($sformatf("d3_%0d_regq", k), 32'(c_regq), (k == 0) ? 32'h0 : 32'hAA0000);
      check($sformatf("d3_%0d_locked", k), 32'(c_locked), 32'h0);
    end

    do_reset();
    for (int k = 0; k < 60; k++) begin
      if (k % 15 == 14) do_reset();
      check_txn($sformatf("rnd%0d", k), 1'($urandom_range(1)), 2'($urandom_range(3)),
                8'($urandom_range(255)), ($urandom_range(3) == 0), ($urandom_range(19) == 0),
                ga, ge);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
